// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer
//   Captures retired register writes from the CPU write-back debug interface
//   into a first-word-fall-through FIFO. A downstream consumer drains it over
//   a valid/ready handshake. Entries that arrive while the FIFO is full are
//   discarded and counted, so any loss in the trace is detectable.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   debug_wb_*          PC / byte write enables / reg number / data of retiring insn
//   capture_en          enable capture; when low nothing is pushed
//   flush               synchronous clear of FIFO and statistics
//   out_valid/out_ready head-entry handshake
//   out_pc/we/wnum/wdata head entry fields (zero while empty)
//   count               occupancy, 0..DEPTH
//   overflow            sticky: at least one entry dropped since reset/flush
//   drop_cnt            saturating count of dropped entries
module wb_trace_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                debug_wb_pc,
  input  logic [3:0]                 debug_wb_rf_we,
  input  logic [4:0]                 debug_wb_rf_wnum,
  input  logic [31:0]                debug_wb_rf_wdata,
  input  logic                       capture_en,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [3:0]                 out_we,
  output logic [4:0]                 out_wnum,
  output logic [31:0]                out_wdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic   push_req, pop, full, push_acc, drop;
  entry_t push_entry;
  entry_t head;

  // Only real register writes are traced: r0 writes and non-writing insns are noise.
  assign push_req = capture_en & (|debug_wb_rf_we) & (debug_wb_rf_wnum != 5'd0);
  assign pop      = out_valid & out_ready;
  assign full     = (count_q == FullCnt);
  // A pop in the same cycle frees the slot being written, so a full FIFO can still accept.
  assign push_acc = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign push_entry = '{pc:    debug_wb_pc,
                        we:    debug_wb_rf_we,
                        wnum:  debug_wb_rf_wnum,
                        wdata: debug_wb_rf_wdata};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (push_acc && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push_acc) begin
      count_d = count_q - (AW+1)'(1);
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != {DROP_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end
  end

  // Reset and flush clear identically; reset simply wins the priority.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage has no reset; a push coinciding with flush/reset is discarded.
  always_ff @(posedge clk) begin
    if (push_acc && !flush && !reset) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    out_valid = (count_q != '0);
    out_pc    = '0;
    out_we    = '0;
    out_wnum  = '0;
    out_wdata = '0;
    if (out_valid) begin
      out_pc    = head.pc;
      out_we    = head.we;
      out_wnum  = head.wnum;
      out_wdata = head.wdata;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DROP_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        capture_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  out_we;
  logic [4:0]  out_wnum;
  logic [31:0] out_wdata;
  logic [4:0]  count;
  logic        overflow;
  logic [DROP_W-1:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_trace_buffer #(
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .capture_en        (capture_en),
    .flush             (flush),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pc            (out_pc),
    .out_we            (out_we),
    .out_wnum          (out_wnum),
    .out_wdata         (out_wdata),
    .count             (count),
    .overflow          (overflow),
    .drop_cnt          (drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [3:0] we, input logic [4:0] wn,
                       input logic [31:0] wd);
    debug_wb_pc       = pc;
    debug_wb_rf_we    = we;
    debug_wb_rf_wnum  = wn;
    debug_wb_rf_wdata = wd;
  endtask

  task automatic idle();
    drive(32'h0, 4'h0, 5'd0, 32'h0);
  endtask

  // Pushes n entries with pc=base_pc+4i, wnum=(i%31)+1, wdata=base_d+i.
  task automatic fill(input int n, input logic [31:0] base_pc, input logic [31:0] base_d);
    for (int i = 0; i < n; i++) begin
      drive(base_pc + 32'(4 * i), 4'hF, 5'((i % 31) + 1), base_d + 32'(i));
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; capture_en = 1'b0; out_ready = 1'b0;
    idle();
    tick(); tick();
    reset = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);

    // Three pushes, consumer stalled; no bypass of the empty FIFO.
    capture_en = 1'b1;
    drive(32'h1c000000, 4'hF, 5'd1, 32'hA);
    chk("nobypass_valid", 64'(out_valid), 64'd0);
    tick();
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_pc", 64'(out_pc), 64'h1c000000);
    drive(32'h1c000004, 4'hF, 5'd2, 32'hB);
    tick();
    drive(32'h1c000008, 4'hF, 5'd3, 32'hC);
    tick();
    idle();
    chk("p3_count", 64'(count), 64'd3);
    tick(); tick();
    chk("hold_pc", 64'(out_pc), 64'h1c000000);
    chk("hold_we", 64'(out_we), 64'hF);
    chk("hold_wnum", 64'(out_wnum), 64'd1);
    chk("hold_wdata", 64'(out_wdata), 64'hA);

    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("drain3_wdata", 64'(out_wdata), 64'(32'hA + 32'(i)));
      chk("drain3_wnum", 64'(out_wnum), 64'(i + 1));
      tick();
    end
    out_ready = 1'b0;
    chk("empty_valid", 64'(out_valid), 64'd0);
    chk("empty_pc", 64'(out_pc), 64'd0);
    chk("empty_wdata", 64'(out_wdata), 64'd0);

    // Filtering: r0 write, non-writing insn, capture disabled.
    drive(32'h2000, 4'hF, 5'd0, 32'h11); tick();
    drive(32'h2004, 4'h0, 5'd5, 32'h22); tick();
    capture_en = 1'b0;
    drive(32'h2008, 4'hF, 5'd6, 32'h33); tick();
    capture_en = 1'b1;
    idle();
    chk("filt_count", 64'(count), 64'd0);
    chk("filt_valid", 64'(out_valid), 64'd0);
    chk("filt_drop", 64'(drop_cnt), 64'd0);

    // Fill to 16 then 3 drops.
    fill(16, 32'h100, 32'hD000);
    chk("full_count", 64'(count), 64'd16);
    chk("full_ovf_pre", 64'(overflow), 64'd0);
    fill(3, 32'h900, 32'hDEAD);
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop", 64'(drop_cnt), 64'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain16_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
      chk("drain16_wdata", 64'(out_wdata), 64'(32'hD000 + 32'(i)));
      tick();
    end
    out_ready = 1'b0;
    chk("drain16_count", 64'(count), 64'd0);

    // Full FIFO with simultaneous push and pop: steady state, order preserved.
    fill(16, 32'h400, 32'hE000);
    out_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      drive(32'h400 + 32'(4 * (16 + j)), 4'hF, 5'd7, 32'hE000 + 32'(16 + j));
      chk("steady_head", 64'(out_wdata), 64'(32'hE000 + 32'(j)));
      tick();
    end
    idle();
    chk("steady_count", 64'(count), 64'd16);
    chk("steady_drop", 64'(drop_cnt), 64'd3);
    for (int j = 20; j < 36; j++) begin
      chk("steady_tail", 64'(out_wdata), 64'(32'hE000 + 32'(j)));
      tick();
    end
    out_ready = 1'b0;
    chk("steady_empty", 64'(count), 64'd0);

    // Flush with count=7, overflow=1 and a concurrent push.
    fill(7, 32'h600, 32'hF000);
    chk("preflush_count", 64'(count), 64'd7);
    chk("preflush_ovf", 64'(overflow), 64'd1);
    flush = 1'b1;
    drive(32'hBAD0, 4'hF, 5'd9, 32'hBAD);
    tick();
    flush = 1'b0;
    idle();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ovf", 64'(overflow), 64'd0);
    chk("flush_drop", 64'(drop_cnt), 64'd0);
    drive(32'h7770, 4'h3, 5'd4, 32'h77);
    tick();
    idle();
    chk("postflush_count", 64'(count), 64'd1);
    chk("postflush_wdata", 64'(out_wdata), 64'h77);
    chk("postflush_we", 64'(out_we), 64'h3);

    // Drop counter saturation at 2^4-1.
    fill(15, 32'h800, 32'hC000);
    chk("sat_full", 64'(count), 64'd16);
    fill(15, 32'hA00, 32'hC100);
    chk("sat_15", 64'(drop_cnt), 64'd15);
    fill(5, 32'hB00, 32'hC200);
    chk("sat_20", 64'(drop_cnt), 64'd15);
    chk("sat_ovf", 64'(overflow), 64'd1);
    chk("sat_head", 64'(out_wdata), 64'h77);

    // Reset wins over flush and clears everything.
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0;
    chk("rst2_count", 64'(count), 64'd0);
    chk("rst2_ovf", 64'(overflow), 64'd0);
    chk("rst2_drop", 64'(drop_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
